// File: rtl/comm_pkg.sv
// Shared comm-line constants and types used by the receive frame assembler
// and the FIFO that carries its output entries.
package comm_pkg;

    localparam int         SYMBOL_BITS  = 10;
    localparam logic [9:0] START_SYMBOL = 10'h1C7;
    localparam logic [9:0] STOP_SYMBOL  = 10'h133;
    localparam logic       FRAME_BIT0   = 1'b1;
    localparam logic       FRAME_BIT9   = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       eop;
        logic       err;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        COLLECT
    } fa_state_t;

    function automatic logic framing_ok(input logic [9:0] sym);
        return (sym[0] == FRAME_BIT0) && (sym[9] == FRAME_BIT9);
    endfunction

endpackage

// File: rtl/comm_sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted only when
// a pop frees a slot in the same cycle.
module comm_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers define what is valid and the
    // head is forced to zero while empty, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/comm_frame_assembler.sv
// Groups decoder bits into 10-bit symbols, strips framing from data symbols
// and queues payload bytes plus an end-of-packet marker for the packet handler.
module comm_frame_assembler
    import comm_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic       inclk,
    input  logic       rst_n,
    input  logic       new_bit,
    input  logic       decoded_bit,
    input  logic       decoding,
    output logic [7:0] out_data,
    output logic       out_eop,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic       err_clear,
    output logic       overflow,
    output logic       truncated,
    output logic [7:0] pkt_count
);

    fa_state_t   state, state_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [9:0]  sym, sym_nxt;
    logic        pkt_err, pkt_err_nxt;
    logic        new_bit_d;
    logic        bit_stb;
    logic        last_bit;
    logic [9:0]  full_sym;
    logic        push_q, push_nxt;
    fifo_entry_t push_entry_q, push_entry_nxt;
    logic        trunc_set;
    logic        pkt_inc;
    fifo_entry_t head_entry;
    logic        fifo_full;
    logic        fifo_empty;
    logic        ovf_set;

    assign bit_stb  = new_bit && !new_bit_d;
    assign last_bit = bit_stb && (bit_cnt == 4'(SYMBOL_BITS - 1));
    // Bits arrive LSB-first, so each new bit enters at the top of the shifter.
    assign full_sym = {decoded_bit, sym[9:1]};

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt      = state;
        bit_cnt_nxt    = bit_cnt;
        sym_nxt        = sym;
        pkt_err_nxt    = pkt_err;
        push_nxt       = 1'b0;
        push_entry_nxt = '0;
        trunc_set      = 1'b0;
        pkt_inc        = 1'b0;
        unique case (state)
            IDLE: begin
                if (bit_stb && decoding) begin
                    state_nxt   = START;
                    bit_cnt_nxt = 4'd1;
                end
            end
            START: begin
                if (!decoding) begin
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else if (last_bit) begin
                    state_nxt   = COLLECT;
                    bit_cnt_nxt = '0;
                    pkt_err_nxt = 1'b0;
                end else if (bit_stb) begin
                    bit_cnt_nxt = bit_cnt + 4'd1;
                end
            end
            COLLECT: begin
                if (!decoding) begin
                    trunc_set   = (bit_cnt != '0);
                    state_nxt   = IDLE;
                    bit_cnt_nxt = '0;
                end else if (bit_stb) begin
                    sym_nxt     = full_sym;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (last_bit) begin
                        bit_cnt_nxt = '0;
                        if (full_sym == STOP_SYMBOL) begin
                            push_nxt       = 1'b1;
                            push_entry_nxt = '{data: 8'h00, eop: 1'b1, err: pkt_err};
                            pkt_inc        = 1'b1;
                            state_nxt      = IDLE;
                        end else if (framing_ok(full_sym)) begin
                            push_nxt       = 1'b1;
                            push_entry_nxt = '{data: full_sym[8:1], eop: 1'b0, err: 1'b0};
                        end else begin
                            pkt_err_nxt = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            sym          <= '0;
            pkt_err      <= 1'b0;
            new_bit_d    <= 1'b0;
            push_q       <= 1'b0;
            push_entry_q <= '0;
        end else begin
            state        <= state_nxt;
            bit_cnt      <= bit_cnt_nxt;
            sym          <= sym_nxt;
            pkt_err      <= pkt_err_nxt;
            new_bit_d    <= new_bit;
            push_q       <= push_nxt;
            push_entry_q <= push_entry_nxt;
        end
    end

    comm_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk       (inclk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (push_entry_q),
        .pop       (out_ready),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A full FIFO is never empty, so out_ready alone means a pop happens.
    assign ovf_set = push_q && fifo_full && !out_ready;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            truncated <= 1'b0;
            pkt_count <= '0;
        end else begin
            if (ovf_set)        overflow <= 1'b1;
            else if (err_clear) overflow <= 1'b0;
            if (trunc_set)      truncated <= 1'b1;
            else if (err_clear) truncated <= 1'b0;
            if (pkt_inc)        pkt_count <= pkt_count + 8'd1;
        end
    end

    assign out_valid = !fifo_empty;
    assign out_data  = head_entry.data;
    assign out_eop   = head_entry.eop;
    assign out_err   = head_entry.err;

endmodule

// File: tb/tb_comm_frame_assembler.sv
// Self-checking bench: a bit-serial decoder model drives symbols while a queue
// model of expected FIFO entries is checked against the head on every cycle.
`timescale 1ns/1ps
module tb_comm_frame_assembler;
    import comm_pkg::*;

    localparam int DEPTH = 16;

    logic       inclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       new_bit = 1'b0;
    logic       decoded_bit = 1'b0;
    logic       decoding = 1'b0;
    logic       out_ready = 1'b0;
    logic       err_clear = 1'b0;
    logic [7:0] out_data;
    logic       out_eop;
    logic       out_err;
    logic       out_valid;
    logic       overflow;
    logic       truncated;
    logic [7:0] pkt_count;

    comm_frame_assembler #(.FIFO_DEPTH(DEPTH), .FIFO_AW(4)) dut (
        .inclk       (inclk),
        .rst_n       (rst_n),
        .new_bit     (new_bit),
        .decoded_bit (decoded_bit),
        .decoding    (decoding),
        .out_data    (out_data),
        .out_eop     (out_eop),
        .out_err     (out_err),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_clear   (err_clear),
        .overflow    (overflow),
        .truncated   (truncated),
        .pkt_count   (pkt_count)
    );

    always #5 inclk = ~inclk;

    int          total = 0;
    int          bad = 0;
    fifo_entry_t exp_q[$];
    logic [7:0]  exp_pkt = 8'd0;
    logic        exp_ovf = 1'b0;
    logic        exp_trunc = 1'b0;
    logic        m_err = 1'b0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Head of the DUT FIFO must always equal the oldest expected entry.
    always @(negedge inclk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("valid_without_expected_entry", 32'(out_valid), 32'd0);
            end else begin
                check("head_data", 32'(out_data), 32'(exp_q[0].data));
                check("head_eop", 32'(out_eop), 32'(exp_q[0].eop));
                check("head_err", 32'(out_err), 32'(exp_q[0].err));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    always @(posedge inclk) begin
        #2;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge inclk);
            #1;
        end
    endtask

    task automatic model_push(input fifo_entry_t e, input bit pulse);
        if (exp_q.size() < DEPTH || pulse) exp_q.push_back(e);
        else exp_ovf = 1'b1;
    endtask

    task automatic model_symbol(input logic [9:0] s, input bit pulse);
        fifo_entry_t e;
        if (s == STOP_SYMBOL) begin
            e = '{data: 8'h00, eop: 1'b1, err: m_err};
            model_push(e, pulse);
            exp_pkt = exp_pkt + 8'd1;
        end else if (s[0] == 1'b1 && s[9] == 1'b0) begin
            e = '{data: s[8:1], eop: 1'b0, err: 1'b0};
            model_push(e, pulse);
        end else begin
            m_err = 1'b1;
        end
    endtask

    // One decoder bit: strobe high for 10 cycles, then a short low gap.
    task automatic send_bit(input logic b, input bit pulse);
        new_bit = 1'b1;
        decoded_bit = b;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (pulse && i == 0) out_ready = 1'b1;
            if (pulse && i == 1) out_ready = 1'b0;
        end
        new_bit = 1'b0;
        decoded_bit = 1'($urandom_range(0, 1));
        tick($urandom_range(1, 3));
    endtask

    task automatic send_symbol(input logic [9:0] s, input int nbits, input bit modeled, input bit pulse);
        if (modeled && nbits == SYMBOL_BITS) model_symbol(s, pulse);
        for (int i = 0; i < nbits; i++) send_bit(s[i], pulse && i == SYMBOL_BITS - 1);
    endtask

    task automatic start_packet();
        decoding = 1'b1;
        tick();
        m_err = 1'b0;
        send_symbol(START_SYMBOL, 10, 1'b0, 1'b0);
    endtask

    task automatic drop_decoding();
        tick(2);
        decoding = 1'b0;
        tick(3);
    endtask

    function automatic logic [9:0] data_sym(input logic [7:0] b);
        return {1'b0, b, 1'b1};
    endfunction

    task automatic pop_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic clear_flags();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        exp_ovf = 1'b0;
        exp_trunc = 1'b0;
    endtask

    task automatic check_status(input string name);
        check({name, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkt));
        check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        check({name, "_truncated"}, 32'(truncated), 32'(exp_trunc));
    endtask

    task automatic drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        tick(2);
        check({name, "_drain_remaining"}, 32'(exp_q.size()), 32'd0);
        check({name, "_drain_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [9:0] s;
        logic [7:0] b;

        // Reset state
        tick(2);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_eop", 32'(out_eop), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_truncated", 32'(truncated), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        @(negedge inclk);
        rst_n = 1'b1;
        tick(2);

        // Basic packet: A5 then clean marker
        start_packet();
        send_symbol(10'h14B, 10, 1'b1, 1'b0);
        send_symbol(STOP_SYMBOL, 10, 1'b1, 1'b0);
        drop_decoding();
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_first_data", 32'(out_data), 32'hA5);
        check("t1_first_eop", 32'(out_eop), 32'd0);
        check("t1_pkt_count", 32'(pkt_count), 32'd1);
        pop_one();
        check("t1_marker_data", 32'(out_data), 32'h00);
        check("t1_marker_eop", 32'(out_eop), 32'd1);
        check("t1_marker_err", 32'(out_err), 32'd0);
        drain("t1");

        // Framing error symbol is dropped and flags the marker
        start_packet();
        send_symbol(10'h14A, 10, 1'b1, 1'b0);
        send_symbol(10'h14B, 10, 1'b1, 1'b0);
        send_symbol(STOP_SYMBOL, 10, 1'b1, 1'b0);
        drop_decoding();
        check("t2_first_data", 32'(out_data), 32'hA5);
        pop_one();
        check("t2_marker_eop", 32'(out_eop), 32'd1);
        check("t2_marker_err", 32'(out_err), 32'd1);
        drain("t2");
        check_status("t2");

        // decoding drops inside the start symbol
        decoding = 1'b1;
        tick();
        send_symbol(START_SYMBOL, 4, 1'b0, 1'b0);
        drop_decoding();
        check("t3_valid", 32'(out_valid), 32'd0);
        check("t3_truncated", 32'(truncated), 32'd0);
        check_status("t3");

        // decoding drops inside a data symbol
        start_packet();
        send_symbol(10'h14B, 10, 1'b1, 1'b0);
        send_symbol(data_sym(8'h3C), 6, 1'b1, 1'b0);
        drop_decoding();
        exp_trunc = 1'b1;
        check("t4_truncated", 32'(truncated), 32'd1);
        check("t4_data", 32'(out_data), 32'hA5);
        pop_one();
        check("t4_no_marker", 32'(out_valid), 32'd0);
        clear_flags();
        check("t4_cleared", 32'(truncated), 32'd0);
        check_status("t4");

        // Overflow: 17 bytes and stop with no consumer
        start_packet();
        for (int i = 1; i <= 17; i++) send_symbol(data_sym(8'(i)), 10, 1'b1, 1'b0);
        send_symbol(STOP_SYMBOL, 10, 1'b1, 1'b0);
        drop_decoding();
        check("t5_overflow", 32'(overflow), 32'd1);
        check("t5_head", 32'(out_data), 32'h01);
        check("t5_held", 32'(exp_q.size()), 32'd16);
        check_status("t5");
        drain("t5");
        clear_flags();
        check_status("t5_clear");

        // Full FIFO with a pop in the push cycle
        start_packet();
        for (int i = 1; i <= 16; i++) send_symbol(data_sym(8'(i)), 10, 1'b1, 1'b0);
        send_symbol(data_sym(8'h11), 10, 1'b1, 1'b1);
        drop_decoding();
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_head_advanced", 32'(out_data), 32'h02);
        check_status("t6");
        drain("t6");

        // Asynchronous reset during COLLECT with 3 entries held
        start_packet();
        for (int i = 0; i < 3; i++) send_symbol(data_sym(8'h50 + 8'(i)), 10, 1'b1, 1'b0);
        send_symbol(data_sym(8'h77), 4, 1'b0, 1'b0);
        check("t7_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        exp_pkt = 8'd0;
        exp_ovf = 1'b0;
        exp_trunc = 1'b0;
        new_bit = 1'b0;
        decoding = 1'b0;
        tick(2);
        @(negedge inclk);
        rst_n = 1'b1;
        tick(2);
        start_packet();
        send_symbol(data_sym(8'h3C), 10, 1'b1, 1'b0);
        send_symbol(STOP_SYMBOL, 10, 1'b1, 1'b0);
        drop_decoding();
        check("t7_after_data", 32'(out_data), 32'h3C);
        check("t7_after_pkt", 32'(pkt_count), 32'd1);
        drain("t7");
        check_status("t7");

        // Randomized packets with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            start_packet();
            for (int k = $urandom_range(1, 6); k > 0; k--) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h99) b = 8'h98;
                case ($urandom_range(0, 5))
                    0:       s = {1'b1, b, 1'b1};
                    1:       s = {1'b0, b, 1'b0};
                    default: s = data_sym(b);
                endcase
                send_symbol(s, 10, 1'b1, 1'b0);
            end
            if ($urandom_range(0, 7) == 0) begin
                send_symbol(data_sym(8'h12), $urandom_range(1, 9), 1'b0, 1'b0);
                exp_trunc = 1'b1;
            end else begin
                send_symbol(STOP_SYMBOL, 10, 1'b1, 1'b0);
            end
            drop_decoding();
        end
        rand_ready = 1'b0;
        tick(2);
        drain("rand");
        check_status("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
